// File: rtl/ddr_mba_rspctl.sv
// ddr_mba_rspctl -- MBA responder (target side) of the arbitration interface.
//
// Accepts MBA requests, acknowledges each with a one-cycle ARB_REL pulse,
// advertises free queue space on ARB_NEL, buffers up to P_QD requests and
// expands each into a stream of 16-byte beats on a valid/ready command port.
//
// Optional feature macro: DDR_MBA_RSP_PAGESPLIT_EN
//   defined   : a request crossing a 2^P_PAGE_W-beat page boundary is split
//               into several FIRST..LAST segments (same beat count).
//   undefined : one FIRST..LAST segment per request; page crossings ignored.
//
// Ports:
//   CLK, ZRESET        clock, asynchronous active-low reset
//   ARB_REQ (in, low)  request, held low until ARB_REL is seen
//   ARB_REL (out)      one-cycle accept pulse
//   ARB_NEL (out)      queue can accept a request (registered)
//   ARB_RZW/ADR/BST    direction (1=read), word address [29:2], beats-1
//   CMD_VALID/READY    beat handshake to the DDR command sequencer
//   CMD_RZW/ADR        beat direction and beat address [29:4]
//   CMD_FIRST/LAST     segment delimiters
//   BUSY (out)         queue non-empty or a request in flight (registered)
module ddr_mba_rspctl #(
  parameter int P_QD     = 2,
  parameter int P_PAGE_W = 6
) (
  input  logic        CLK,
  input  logic        ZRESET,
  input  logic        ARB_REQ,
  output logic        ARB_REL,
  output logic        ARB_NEL,
  input  logic        ARB_RZW,
  input  logic [27:0] ARB_ADR,
  input  logic [7:0]  ARB_BST,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic        CMD_RZW,
  output logic [25:0] CMD_ADR,
  output logic        CMD_FIRST,
  output logic        CMD_LAST,
  output logic        BUSY
);

`ifdef DDR_MBA_RSP_PAGESPLIT_EN
  localparam bit LP_SPLIT = 1'b1;
`else
  localparam bit LP_SPLIT = 1'b0;
`endif

  localparam int PW = (P_QD > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam int EW = 35;  // {rzw, adr[29:4], bst}
  localparam logic [CW-1:0] LP_FULL = CW'(P_QD);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [EW-1:0] r_q [P_QD];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_rel, r_nel, r_busy;
  state_t        r_state;
  logic [25:0]   r_adr;
  logic [7:0]    r_rem;
  logic          r_rzw, r_first, r_last;

  state_t        w_state_nxt;
  logic          w_push, w_pop, w_hs, w_hs_done;
  logic [CW-1:0] w_cnt_nxt;
  logic [EW-1:0] w_head;
  logic          w_head_rzw;
  logic [25:0]   w_head_adr, w_head_a1, w_adr_n1, w_adr_n2;
  logic [7:0]    w_head_bst;
  logic          w_ld_last, w_nx_last;
  logic          w_unused;

  // Byte-in-beat address bits carry no information for 16-byte beats.
  assign w_unused = ^ARB_ADR[1:0];

  // ~r_rel blocks a second capture while the initiator still holds ARB_REQ
  // low in the cycle it sees the acknowledge.
  assign w_push    = ~ARB_REQ & ~r_rel & (r_cnt != LP_FULL);
  assign w_pop     = (r_state == S_IDLE) & (r_cnt != '0);
  assign w_hs      = (r_state == S_RUN) & CMD_READY;
  assign w_hs_done = w_hs & (r_rem == 8'd0);
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

  assign w_head     = r_q[r_rp];
  assign w_head_rzw = w_head[34];
  assign w_head_adr = w_head[33:8];
  assign w_head_bst = w_head[7:0];

  // A beat closes its segment when the beat after it starts a new page.
  assign w_head_a1 = w_head_adr + 26'd1;
  assign w_adr_n1  = r_adr + 26'd1;
  assign w_adr_n2  = r_adr + 26'd2;
  assign w_ld_last = (w_head_bst == 8'd0) |
                     (LP_SPLIT & (w_head_a1[P_PAGE_W-1:0] == '0));
  assign w_nx_last = (r_rem == 8'd1) |
                     (LP_SPLIT & (w_adr_n2[P_PAGE_W-1:0] == '0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop)     w_state_nxt = S_RUN;
      S_RUN:   if (w_hs_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Queue storage needs no reset: occupancy is tracked by r_cnt alone.
  always_ff @(posedge CLK) begin
    if (w_push) r_q[r_wp] <= {ARB_RZW, ARB_ADR[27:2], ARB_BST};
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_rel  <= 1'b0;
      r_nel  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt  <= w_cnt_nxt;
      r_rel  <= w_push;
      r_nel  <= (w_cnt_nxt != LP_FULL);
      r_busy <= (w_cnt_nxt != '0) | (w_state_nxt != S_IDLE);
    end
  end

  // Beat generator: loads on pop, advances on every handshake.
  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      r_adr   <= '0;
      r_rem   <= '0;
      r_rzw   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_pop) begin
      r_adr   <= w_head_adr;
      r_rem   <= w_head_bst;
      r_rzw   <= w_head_rzw;
      r_first <= 1'b1;
      r_last  <= w_ld_last;
    end else if (w_hs & ~w_hs_done) begin
      r_adr   <= w_adr_n1;
      r_rem   <= r_rem - 8'd1;
      r_first <= LP_SPLIT & r_last;
      r_last  <= w_nx_last;
    end
  end

  assign ARB_REL   = r_rel;
  assign ARB_NEL   = r_nel;
  assign BUSY      = r_busy;
  assign CMD_VALID = (r_state == S_RUN);
  assign CMD_RZW   = r_rzw;
  assign CMD_ADR   = r_adr;
  assign CMD_FIRST = r_first;
  assign CMD_LAST  = r_last;

endmodule

// File: tb/tb_ddr_mba_rspctl.sv
module tb_ddr_mba_rspctl;
`ifdef DDR_MBA_RSP_PAGESPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int PAGE_W = 6;

  logic        CLK = 1'b0;
  logic        ZRESET = 1'b0;
  logic        ARB_REQ = 1'b1;
  logic        ARB_REL, ARB_NEL;
  logic        ARB_RZW = 1'b0;
  logic [27:0] ARB_ADR = '0;
  logic [7:0]  ARB_BST = '0;
  logic        CMD_VALID;
  logic        CMD_READY = 1'b0;
  logic        CMD_RZW;
  logic [25:0] CMD_ADR;
  logic        CMD_FIRST, CMD_LAST;
  logic        BUSY;

  ddr_mba_rspctl #(.P_QD(2), .P_PAGE_W(PAGE_W)) dut (
    .CLK(CLK), .ZRESET(ZRESET),
    .ARB_REQ(ARB_REQ), .ARB_REL(ARB_REL), .ARB_NEL(ARB_NEL),
    .ARB_RZW(ARB_RZW), .ARB_ADR(ARB_ADR), .ARB_BST(ARB_BST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RZW(CMD_RZW),
    .CMD_ADR(CMD_ADR), .CMD_FIRST(CMD_FIRST), .CMD_LAST(CMD_LAST),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rzw;
    logic [25:0] adr;
    logic        first;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    src_done = 1'b1;

  // Reference: a request is bst+1 consecutive beat addresses (mod 2^26);
  // segments break at page boundaries only when splitting is enabled.
  task automatic model_push(input logic rzw, input logic [27:0] adr, input logic [7:0] bst);
    beat_t b;
    logic [25:0] a, an;
    for (int i = 0; i <= int'(bst); i++) begin
      a  = adr[27:2] + 26'(i);
      an = a + 26'd1;
      b.rzw   = rzw;
      b.adr   = a;
      b.first = (i == 0) || (SPLIT && (a[PAGE_W-1:0] == '0));
      b.last  = (i == int'(bst)) || (SPLIT && (an[PAGE_W-1:0] == '0));
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_rel(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge CLK); n++;
      if (ARB_REL) break;
    end
    checks++;
    if (!ARB_REL) begin
      errors++;
      $display("FAIL rel_timeout: got REL=%0b want 1 within %0d cycles", ARB_REL, budget);
    end else begin
      model_push(ARB_RZW, ARB_ADR, ARB_BST);
    end
    ARB_REQ = 1'b1;
  endtask

  task automatic issue(input logic rzw, input logic [27:0] adr, input logic [7:0] bst);
    @(negedge CLK);
    ARB_REQ = 1'b0; ARB_RZW = rzw; ARB_ADR = adr; ARB_BST = bst;
    wait_rel(400);
  endtask

  // Consume beats, comparing each handshake against the model and checking
  // that a stalled beat stays put.
  task automatic run_beats(input int budget, input bit rnd);
    int    n = 0;
    bit    stall = 1'b0;
    beat_t pv, cur, b;
    while (n < budget && !(src_done && exp_q.size() == 0)) begin
      @(negedge CLK); n++;
      cur = {CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST};
      if (stall) begin
        checks++;
        if (!CMD_VALID || cur !== pv) begin
          errors++;
          $display("FAIL hold: got v=%0b %h want v=1 %h", CMD_VALID, cur, pv);
        end
      end
      CMD_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = CMD_VALID && !CMD_READY;
      pv = cur;
      if (CMD_VALID && CMD_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got beat %h want none", cur);
        end else begin
          b = exp_q.pop_front();
          if (cur !== b) begin
            errors++;
            $display("FAIL beat: got rzw=%0b adr=%h f=%0b l=%0b want rzw=%0b adr=%h f=%0b l=%0b",
                     cur.rzw, cur.adr, cur.first, cur.last, b.rzw, b.adr, b.first, b.last);
          end
        end
      end
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats pending want 0", exp_q.size());
    end
    @(posedge CLK); #1;
    CMD_READY = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({ARB_REL, ARB_NEL, CMD_VALID, CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got rel=%0b nel=%0b v=%0b adr=%h busy=%0b want all 0",
               ARB_REL, ARB_NEL, CMD_VALID, CMD_ADR, BUSY);
    end
    repeat (2) @(negedge CLK);
    ZRESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (ARB_NEL !== 1'b1 || CMD_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got nel=%0b v=%0b busy=%0b want 1 0 0", ARB_NEL, CMD_VALID, BUSY);
    end
  endtask

  task automatic test_single;
    CMD_READY = 1'b0;
    @(negedge CLK);
    ARB_REQ = 1'b0; ARB_RZW = 1'b0; ARB_ADR = 28'h0000040; ARB_BST = 8'h03;
    @(negedge CLK);
    checks++;
    if (ARB_REL !== 1'b1 || CMD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_rel: got rel=%0b v=%0b want 1 0", ARB_REL, CMD_VALID);
    end
    ARB_REQ = 1'b1;
    model_push(1'b0, 28'h0000040, 8'h03);
    @(negedge CLK);
    checks++;
    if (ARB_REL !== 1'b0 || CMD_VALID !== 1'b1 || CMD_ADR !== 26'h10 || CMD_FIRST !== 1'b1) begin
      errors++;
      $display("FAIL single_first: got rel=%0b v=%0b adr=%h f=%0b want 0 1 10 1",
               ARB_REL, CMD_VALID, CMD_ADR, CMD_FIRST);
    end
    run_beats(100, 1'b0);
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || ARB_NEL !== 1'b1 || CMD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%0b nel=%0b v=%0b want 0 1 0", BUSY, ARB_NEL, CMD_VALID);
    end
  endtask

  task automatic test_backpressure;
    beat_t pv;
    CMD_READY = 1'b0;
    issue(1'b1, 28'h1234568, 8'h01);
    @(negedge CLK);
    pv = {CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST};
    checks++;
    if (CMD_VALID !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: got v=%0b busy=%0b want 1 1", CMD_VALID, BUSY);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (CMD_VALID !== 1'b1 || {CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST} !== pv) begin
        errors++;
        $display("FAIL bp_hold: got v=%0b %h want v=1 %h", CMD_VALID,
                 {CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST}, pv);
      end
    end
    run_beats(100, 1'b0);
  endtask

  task automatic test_queue_full;
    int rel_seen = 0;
    CMD_READY = 1'b0;
    issue(1'b0, 28'h0000100, 8'h01);
    issue(1'b1, 28'h0000200, 8'h02);
    issue(1'b0, 28'h0000300, 8'h00);
    checks++;
    if (ARB_NEL !== 1'b0) begin
      errors++;
      $display("FAIL full_nel: got nel=%0b want 0", ARB_NEL);
    end
    @(negedge CLK);
    ARB_REQ = 1'b0; ARB_RZW = 1'b1; ARB_ADR = 28'h0000400; ARB_BST = 8'h03;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ARB_REL || ARB_NEL) rel_seen++;
    end
    checks++;
    if (rel_seen != 0) begin
      errors++;
      $display("FAIL full_block: got %0d cycles with rel/nel high want 0", rel_seen);
    end
    fork
      wait_rel(400);
      run_beats(2000, 1'b0);
    join
  endtask

  task automatic test_max_burst;
    issue(1'b0, {26'h3FFFFFE, 2'b00}, 8'hFF);
    run_beats(3000, 1'b1);
  endtask

  task automatic test_page;
    issue(1'b1, {26'h000003E, 2'b11}, 8'h03);
    run_beats(100, 1'b0);
  endtask

  task automatic test_random;
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [27:0] a;
          logic [7:0]  b;
          a = 28'($urandom);
          if (i % 3 == 0) a[7:2] = 6'h3C;
          b = (i % 7 == 0) ? 8'($urandom_range(40, 90)) : 8'($urandom_range(0, 12));
          issue(1'($urandom_range(0, 1)), a, b);
        end
        src_done = 1'b1;
      end
      run_beats(20000, 1'b1);
    join
  endtask

  task automatic test_reset_mid;
    int hs = 0;
    int bad = 0;
    CMD_READY = 1'b0;
    issue(1'b0, 28'h0000100, 8'h03);
    CMD_READY = 1'b1;
    for (int i = 0; i < 20 && hs < 2; i++) begin
      @(negedge CLK);
      if (CMD_VALID && CMD_READY) hs++;
    end
    @(posedge CLK); #2;
    checks++;
    if (CMD_VALID !== 1'b1 || CMD_ADR !== 26'h42) begin
      errors++;
      $display("FAIL mid_beat2: got v=%0b adr=%h want 1 42", CMD_VALID, CMD_ADR);
    end
    ZRESET = 1'b0;
    #1;
    checks++;
    if ({ARB_REL, ARB_NEL, CMD_VALID, CMD_RZW, CMD_ADR, CMD_FIRST, CMD_LAST, BUSY} !== '0) begin
      errors++;
      $display("FAIL mid_reset_vals: got nel=%0b v=%0b adr=%h l=%0b busy=%0b want all 0",
               ARB_NEL, CMD_VALID, CMD_ADR, CMD_LAST, BUSY);
    end
    exp_q.delete();
    CMD_READY = 1'b0;
    repeat (2) @(negedge CLK);
    ZRESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (ARB_NEL !== 1'b1 || CMD_VALID !== 1'b0 || BUSY !== 1'b0 || ARB_REL !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got nel=%0b v=%0b busy=%0b rel=%0b want 1 0 0 0",
               ARB_NEL, CMD_VALID, BUSY, ARB_REL);
    end
    CMD_READY = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (CMD_VALID || BUSY) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_residual: got %0d cycles valid/busy want 0", bad);
    end
    CMD_READY = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_queue_full;
    test_max_burst;
    test_page;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
